mem_stall_bridge: RTL
=====================

// Module: mem_stall_bridge
//
// PURPOSE
// - Variable-latency memory bridge for the next-generation multicycle RV64 core.
// - Replaces the fixed single-cycle memory port. Turns each core access (instr fetch, load, store) into one valid/ready request plus one rvalid response on an external memory bus.
// - Asserts o_stall so the core FSM freezes until the access completes. Sits between the core datapath and the memory/bus fabric.
//
// PARAMETERS
// - ADDR_WIDTH     64  core/memory byte-address width
// - DATA_WIDTH     64  memory data width, 32 or 64; bytes/beat NB = DATA_WIDTH/8
// - TIMEOUT_CYCLES 256 max cycles in REQ+WAIT before error completion; 0 disables the timeout
// - CNT_WIDTH      32  stall-cycle counter width
//
// PORTS
// - clk             in  1           clock, all logic on rising edge
// - arst            in  1           asynchronous reset, active-high
// - i_core_req      in  1           core access request, held high until o_core_done
// - i_core_we       in  1           1 = store, 0 = load/fetch
// - i_core_size     in  2           00 byte, 01 half, 10 word, 11 dword (func_3[1:0])
// - i_core_addr     in  ADDR_WIDTH  byte address
// - i_core_wdata    in  DATA_WIDTH  store data, right-justified
// - o_core_rdata    out DATA_WIDTH  load data, right-justified, zero-filled above size
// - o_core_done     out 1           1-cycle completion pulse
// - o_core_err      out 1           valid with o_core_done: misaligned, bus error or timeout
// - o_stall         out 1           core must hold state
// - o_mem_valid     out 1           request valid
// - i_mem_ready     in  1           memory accepts request
// - o_mem_we        out 1           request is a write
// - o_mem_addr      out ADDR_WIDTH  beat-aligned address (low log2(NB) bits = 0)
// - o_mem_wstrb     out NB          byte-lane strobes
// - o_mem_wdata     out DATA_WIDTH  write data shifted into lanes
// - i_mem_rvalid    in  1           response (read data or write ack)
// - i_mem_rdata     in  DATA_WIDTH  read beat
// - i_mem_err       in  1           bus error, qualified by i_mem_rvalid
// - o_stall_cnt     out CNT_WIDTH   saturating count of cycles with o_stall = 1
//
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0, including o_core_rdata and o_stall_cnt. Reset mid-transaction drops the access. A late rvalid arriving in IDLE is ignored.
// - States: IDLE, REQ, WAIT, DONE.
// - IDLE:
//   - i_core_req && aligned: latch addr/we/size/wdata, go to REQ.
//   - i_core_req && misaligned, or size 11 with DATA_WIDTH=32: go to DONE with err = 1, rdata = 0. No bus request is issued.
// - Alignment: the address offset must be a multiple of the access size.
// - REQ:
//   - o_mem_valid = 1. Addr, we, strb and wdata come from registers and stay stable until ready.
//   - ready && rvalid in the same cycle: go to DONE.
//   - ready only: go to WAIT.
// - WAIT: on rvalid, go to DONE.
// - Any rvalid: capture rdata shifted right by offset*8 and masked to size. Capture err from i_mem_err.
// - Timeout: cycle counter runs through REQ+WAIT. When it reaches TIMEOUT_CYCLES, go to DONE with err = 1 and rdata = 0. If this happens in REQ, o_mem_valid drops; this is the only permitted valid withdrawal.
// - DONE: o_core_done = 1 for exactly one cycle, then always IDLE, so a still-high req cannot double-issue.
//   - Minimum back-to-back spacing: 3 cycles per access.
// - Latency: req first seen in IDLE at cycle 0, valid at cycle 1. A zero-wait memory (ready & rvalid at cycle 1) gives done at cycle 2.
// - i_core_req dropping after IDLE: ignored, the transaction completes.
// - o_stall = (IDLE && i_core_req) || REQ || WAIT; combinational from state and req. Low in DONE.
// - o_stall_cnt: +1 on each o_stall cycle; holds at all-ones.
// - Strobes: size bytes starting at lane offset, e.g. half @ offset 6 -> 8'b1100_0000.
// - o_core_rdata and o_core_err hold their values until the next DONE.
//
// STRUCTURE
// - mem_bridge_pkg:
//   - bridge_state_t enum {IDLE, REQ, WAIT, DONE}
//   - size localparams SZ_B/SZ_H/SZ_W/SZ_D
//   - function size_bytes()
// - Sub-module mem_lane_align (combinational):
//   - in: addr offset, size, wdata, rdata
//   - out: wstrb, lane-shifted wdata, right-justified masked rdata, misaligned flag
// - The top holds the FSM, request registers, timeout counter and stall counter.
//
// TESTING
// - Zero-wait load dword @0x100, rdata=0x1122334455667788 with ready+rvalid in one cycle -> done at cycle 2, rdata=0x1122334455667788, err=0, stall high 2 cycles.
// - Store half 0xBEEF @0x106, ready after 3 cycles, rvalid 2 cycles later -> mem_addr=0x100, wstrb=0xC0, wdata=0xBEEF<<48, valid stable until ready, one done pulse.
// - Load word @0x102 (misaligned) -> no o_mem_valid, done 1 cycle after req, err=1, rdata=0.
// - TIMEOUT_CYCLES=4, ready held low -> valid for 4 cycles then drops, done with err=1, stall_cnt +=5.
// - Reset asserted in WAIT, then rvalid arrives -> outputs 0, state IDLE, no done pulse, rvalid ignored.
// - CNT_WIDTH=3, 9 stalled cycles -> o_stall_cnt saturates at 7.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the variable-latency core-to-memory stall bridge.
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } bridge_state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    function automatic int size_bytes(input logic [1:0] size);
        return 1 << size;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between right-justified core data and a beat-wide memory bus.
module mem_lane_align
    import mem_bridge_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    localparam int NB         = DATA_WIDTH / 8,
    localparam int OFFW       = $clog2(NB)
) (
    input  logic [OFFW-1:0]       off_i,
    input  logic [1:0]            size_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [NB-1:0]         wstrb_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  misaligned_o
);

    int                    nbytes;
    int                    off;
    logic [DATA_WIDTH-1:0] wdata_m;
    logic [DATA_WIDTH-1:0] rdata_s;

    always_comb begin
        nbytes  = size_bytes(size_i);
        off     = int'(off_i);
        wstrb_o = '0;
        wdata_m = '0;
        rdata_o = '0;
        rdata_s = rdata_i >> {off_i, 3'b000};
        // An access wider than the beat can never be aligned.
        misaligned_o = (nbytes > NB) || ((off & (nbytes - 1)) != 0);
        for (int i = 0; i < NB; i++) begin
            wstrb_o[i] = (i >= off) && (i < off + nbytes);
            if (i < nbytes) begin
                wdata_m[8*i +: 8] = wdata_i[8*i +: 8];
                rdata_o[8*i +: 8] = rdata_s[8*i +: 8];
            end
        end
        wdata_o = wdata_m << {off_i, 3'b000};
    end

endmodule

// File: rtl/mem_stall_bridge.sv
// Turns one held core access into a valid/ready request plus rvalid response,
// stalling the core until a one-cycle done pulse.
module mem_stall_bridge
    import mem_bridge_pkg::*;
#(
    parameter  int ADDR_WIDTH     = 64,
    parameter  int DATA_WIDTH     = 64,
    parameter  int TIMEOUT_CYCLES = 256,
    parameter  int CNT_WIDTH      = 32,
    localparam int NB             = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_core_req,
    input  logic                  i_core_we,
    input  logic [1:0]            i_core_size,
    input  logic [ADDR_WIDTH-1:0] i_core_addr,
    input  logic [DATA_WIDTH-1:0] i_core_wdata,
    output logic [DATA_WIDTH-1:0] o_core_rdata,
    output logic                  o_core_done,
    output logic                  o_core_err,
    output logic                  o_stall,
    output logic                  o_mem_valid,
    input  logic                  i_mem_ready,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [NB-1:0]         o_mem_wstrb,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_err,
    output logic [CNT_WIDTH-1:0]  o_stall_cnt
);

    localparam int OFFW     = $clog2(NB);
    localparam int TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit TMO_EN   = (TIMEOUT_CYCLES > 0);

    bridge_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic [NB-1:0]         wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [OFFW-1:0]       al_off;
    logic [1:0]            al_size;
    logic [NB-1:0]         al_wstrb;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [DATA_WIDTH-1:0] al_rdata;
    logic                  al_mis;
    logic                  tmo_hit;
    logic                  stall;

    // In IDLE the aligner checks the incoming request; afterwards it steers
    // the response using the latched offset and size.
    assign al_off  = (state_q == IDLE) ? i_core_addr[OFFW-1:0] : addr_q[OFFW-1:0];
    assign al_size = (state_q == IDLE) ? i_core_size : size_q;

    mem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .off_i        (al_off),
        .size_i       (al_size),
        .wdata_i      (i_core_wdata),
        .rdata_i      (i_mem_rdata),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_mis)
    );

    assign tmo_hit = TMO_EN && (tmo_q == TW'(TMO_LAST));
    assign stall   = ((state_q == IDLE) && i_core_req) || (state_q == REQ) || (state_q == WAIT);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = '0;
        cnt_d   = (stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        case (state_q)
            IDLE: begin
                if (i_core_req) begin
                    if (al_mis) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = REQ;
                        addr_d  = i_core_addr;
                        we_d    = i_core_we;
                        size_d  = i_core_size;
                        wstrb_d = al_wstrb;
                        wdata_d = al_wdata;
                    end
                end
            end
            REQ: begin
                tmo_d = tmo_q + 1'b1;
                // A response in the final cycle beats the timeout.
                if (i_mem_ready && i_mem_rvalid) begin
                    state_d = DONE;
                    rdata_d = al_rdata;
                    err_d   = i_mem_err;
                end else if (tmo_hit) begin
                    state_d = DONE;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else if (i_mem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (i_mem_rvalid) begin
                    state_d = DONE;
                    rdata_d = al_rdata;
                    err_d   = i_mem_err;
                end else if (tmo_hit) begin
                    state_d = DONE;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_core_rdata = rdata_q;
    assign o_core_err   = err_q;
    assign o_core_done  = (state_q == DONE);
    assign o_stall      = stall;
    assign o_mem_valid  = (state_q == REQ);
    assign o_mem_we     = we_q;
    assign o_mem_addr   = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
    assign o_mem_wstrb  = wstrb_q;
    assign o_mem_wdata  = wdata_q;
    assign o_stall_cnt  = cnt_q;

endmodule
